// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux_rr slice: arbitration mode codes,
// default channel count / data width, and a small index-wrap helper.
package stream_mux_pkg;

  // Arbitration mode codes for the ARB_MODE parameter
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Default geometry of the multiplexer
  localparam int DEFAULT_NUM_CH = 16;
  localparam int DEFAULT_WIDTH  = 32;

  // Wraps an index that may have run past the channel count by at most
  // one full lap back into the range 0..n-1.
  function automatic int wrapIndex(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational grant selection over NUM_CH requesters with a
// registered "last granted" pointer. ARB_MODE selects fixed priority (lowest
// index wins) or round robin (search starts one past the last grant).
// When i_lock is high the grant is pinned to the last granted channel, which
// lets the parent hold a channel for the remainder of a packet.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH   = DEFAULT_NUM_CH,
  parameter  int ARB_MODE = ARB_RR,
  localparam int IDXW     = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_request,
  input  logic              i_advance,
  input  logic              i_lock,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDXW-1:0]   o_index
);

  logic [IDXW-1:0] lastGrant_q;
  logic [IDXW-1:0] lastGrant_d;
  logic            found;

  // Pick the winning requester from the current requests and pointer
  always_comb begin
    o_grant = '0;
    o_index = '0;
    found   = 1'b0;
    if (i_lock) begin
      if (i_request[lastGrant_q]) begin
        o_grant[lastGrant_q] = 1'b1;
        o_index              = lastGrant_q;
      end
    end else if (ARB_MODE == ARB_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && i_request[i]) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_index    = IDXW'(i);
        end
      end
    end else begin
      for (int off = 1; off <= NUM_CH; off++) begin
        int k;
        k = wrapIndex(int'(lastGrant_q) + off, NUM_CH);
        if (!found && i_request[k]) begin
          found      = 1'b1;
          o_grant[k] = 1'b1;
          o_index    = IDXW'(k);
        end
      end
    end
  end

  // The pointer only moves when a beat actually transfers
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (i_advance) begin
      lastGrant_d = o_index;
    end
  end

  // Pointer register; reset parks it on the top channel so channel 0 wins first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lastGrant_q <= IDXW'(NUM_CH - 1);
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-input valid/ready stream multiplexer with a single
// registered output stage. rr_arbiter picks the source each beat; this module
// owns the data select, the output register and the optional packet lock.
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN -- when defined, once a
// channel starts a packet the grant stays with it until its i_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH   = DEFAULT_NUM_CH,
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int ARB_MODE = ARB_RR,
  localparam int SELW     = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_valid,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]       i_last,
  output logic [NUM_CH-1:0]       o_ready,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_last,
  output logic [SELW-1:0]         o_sel,
  input  logic                    i_ready
);

  logic [NUM_CH-1:0] grant;
  logic [SELW-1:0]   grantIdx;
  logic              load;
  logic              transfer;
  logic              lockActive;
  logic [WIDTH-1:0]  selData;
  logic              selLast;

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              last_q,  last_d;
  logic [SELW-1:0]   sel_q,   sel_d;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arbiter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_request (i_valid),
    .i_advance (transfer),
    .i_lock    (lockActive),
    .o_grant   (grant),
    .o_index   (grantIdx)
  );

  // The output register can take a beat when empty or being drained this cycle;
  // no channel is accepted while reset is asserted
  always_comb begin
    load     = ~valid_q | i_ready;
    o_ready  = (i_rst || !load) ? '0 : grant;
    transfer = |(o_ready & i_valid);
  end

  // Route the granted channel's payload toward the output register
  always_comb begin
    selData = i_data[int'(grantIdx)*WIDTH +: WIDTH];
    selLast = i_last[grantIdx];
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic lock_q, lock_d;

  // A non-final beat opens a packet and pins the arbiter; the final beat releases it
  always_comb begin
    lock_d = lock_q;
    if (transfer) begin
      lock_d = ~selLast;
    end
  end

  // Packet lock register; reset abandons any packet in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lockActive = lock_q;
`else
  assign lockActive = 1'b0;
`endif

  // Capture on a transfer, otherwise empty the stage once downstream takes it
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (transfer) begin
      valid_d = 1'b1;
      data_d  = selData;
      last_d  = selLast;
      sel_d   = grantIdx;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output stage register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr with NUM_CH=4, WIDTH=32. A round-robin instance
// is checked against a transaction-level reference model; a fixed-priority
// instance shares the same inputs for the priority scenario.
// Honours STREAM_MUX_PKT_LOCK_EN in its model when the macro is defined.
module tb_stream_mux_rr;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] valid;
  logic [NCH*W-1:0] data;
  logic [NCH-1:0] last;
  logic           ready;

  logic [NCH-1:0] rrReady;
  logic           rrValid;
  logic [W-1:0]   rrData;
  logic           rrLast;
  logic [1:0]     rrSel;

  logic [NCH-1:0] fxReady;
  logic           fxValid;
  logic [W-1:0]   fxData;
  logic           fxLast;
  logic [1:0]     fxSel;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  bit          mValid;
  logic [W-1:0] mData;
  bit          mLast;
  int          mSel;
  int          mLastGrant;
  bit          mLocked;

  stream_mux_rr #(.NUM_CH(NCH), .WIDTH(W), .ARB_MODE(1)) dutRr (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_last(last),
    .o_ready(rrReady), .o_valid(rrValid), .o_data(rrData), .o_last(rrLast),
    .o_sel(rrSel), .i_ready(ready)
  );

  stream_mux_rr #(.NUM_CH(NCH), .WIDTH(W), .ARB_MODE(0)) dutFix (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_last(last),
    .o_ready(fxReady), .o_valid(fxValid), .o_data(fxData), .o_last(fxLast),
    .o_sel(fxSel), .i_ready(ready)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which channel the model says is accepted this cycle (one-hot or zero)
  function automatic logic [NCH-1:0] modelReady();
    if (rst) return '0;
    if (mValid && !ready) return '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (mLocked) return valid[mLastGrant] ? NCH'(1 << mLastGrant) : '0;
`endif
    for (int off = 1; off <= NCH; off++) begin
      int k;
      k = (mLastGrant + off) % NCH;
      if (valid[k]) return NCH'(1 << k);
    end
    return '0;
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT
  task automatic tick();
    logic [NCH-1:0] r;
    r = modelReady();
    if (rst) begin
      mValid = 0; mData = '0; mLast = 0; mSel = 0;
      mLastGrant = NCH - 1; mLocked = 0;
    end else if (r != '0) begin
      int k;
      k = 0;
      for (int i = 0; i < NCH; i++) if (r[i]) k = i;
      mValid = 1;
      mData = data[k*W +: W];
      mLast = last[k];
      mSel = k;
      mLastGrant = k;
      mLocked = !last[k];
    end else if (ready) begin
      mValid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setChData(input int ch, input logic [W-1:0] v);
    data[ch*W +: W] = v;
  endtask

  task automatic test_reset();
    rst = 1; valid = 4'b1111; last = 4'b1111; ready = 1; data = '1;
    tick(); tick();
    #1;
    checkCount++;
    if (rrReady !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", rrReady);
    else passCount++;
    checkCount++;
    if (rrValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", rrValid);
    else passCount++;
    checkCount++;
    if (rrData !== 32'h0 || rrLast !== 1'b0 || rrSel !== 2'd0)
      $display("[TB] FAIL reset_regs: got data=%h last=%b sel=%0d expected 0/0/0", rrData, rrLast, rrSel);
    else passCount++;
  endtask

  task automatic test_rr_sweep();
    rst = 0; valid = 4'b1111; last = 4'b1111; ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkCount++;
      if (rrReady !== NCH'(1 << (i % NCH)))
        $display("[TB] FAIL sweep_ready[%0d]: got %b expected %b", i, rrReady, NCH'(1 << (i % NCH)));
      else passCount++;
      tick();
      checkCount++;
      if (rrSel !== 2'(i % NCH) || rrValid !== 1'b1)
        $display("[TB] FAIL sweep_sel[%0d]: got sel=%0d valid=%b expected sel=%0d valid=1", i, rrSel, rrValid, i % NCH);
      else passCount++;
    end
  endtask

  task automatic test_backpressure();
    valid = 4'b0000; ready = 1;
    tick();
    checkCount++;
    if (rrValid !== 1'b0) $display("[TB] FAIL bp_drain: got valid=%b expected 0", rrValid);
    else passCount++;
    valid = 4'b0100; setChData(2, 32'hDEAD_BEEF);
    #1;
    checkCount++;
    if (rrReady !== 4'b0100) $display("[TB] FAIL bp_first_ready: got %b expected 0100", rrReady);
    else passCount++;
    tick();
    checkCount++;
    if (rrData !== 32'hDEAD_BEEF || rrSel !== 2'd2)
      $display("[TB] FAIL bp_capture: got data=%h sel=%0d expected deadbeef/2", rrData, rrSel);
    else passCount++;
    ready = 0; setChData(2, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCount++;
      if (rrReady !== 4'b0000) $display("[TB] FAIL bp_stall_ready[%0d]: got %b expected 0000", i, rrReady);
      else passCount++;
      tick();
      checkCount++;
      if (rrData !== 32'hDEAD_BEEF || rrValid !== 1'b1)
        $display("[TB] FAIL bp_hold[%0d]: got data=%h valid=%b expected deadbeef/1", i, rrData, rrValid);
      else passCount++;
    end
    ready = 1;
    #1;
    checkCount++;
    if (rrReady !== 4'b0100) $display("[TB] FAIL bp_release_ready: got %b expected 0100", rrReady);
    else passCount++;
    tick();
    checkCount++;
    if (rrData !== 32'hCAFE_F00D) $display("[TB] FAIL bp_next_beat: got %h expected cafef00d", rrData);
    else passCount++;
  endtask

  task automatic test_idle();
    valid = 4'b0000; ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkCount++;
      if (rrReady !== 4'b0000) $display("[TB] FAIL idle_ready[%0d]: got %b expected 0000", i, rrReady);
      else passCount++;
      tick();
      checkCount++;
      if (rrValid !== 1'b0) $display("[TB] FAIL idle_valid[%0d]: got %b expected 0", i, rrValid);
      else passCount++;
    end
    valid = 4'b1111;
    #1;
    checkCount++;
    if (rrReady !== 4'b1000) $display("[TB] FAIL idle_pointer: got %b expected 1000", rrReady);
    else passCount++;
    tick();
  endtask

  task automatic test_fixed_priority();
    rst = 1; tick(); rst = 0;
    valid = 4'b1010; last = 4'b1111; ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkCount++;
      if (fxReady !== 4'b0010) $display("[TB] FAIL fixed_ready[%0d]: got %b expected 0010", i, fxReady);
      else passCount++;
      tick();
      checkCount++;
      if (fxSel !== 2'd1 || fxValid !== 1'b1)
        $display("[TB] FAIL fixed_sel[%0d]: got sel=%0d valid=%b expected 1/1", i, fxSel, fxValid);
      else passCount++;
      checkCount++;
      if (rrSel !== 2'(mSel)) $display("[TB] FAIL fixed_rr_sel[%0d]: got %0d expected %0d", i, rrSel, mSel);
      else passCount++;
    end
  endtask

  task automatic test_lock();
    int expSel[4];
    expSel[0] = 1; expSel[1] = 1; expSel[2] = 1; expSel[3] = 0;
    ready = 1; valid = 4'b0001; last = 4'b1111;
    tick();
    valid = 4'b0011;
    for (int b = 0; b < 4; b++) begin
      last = (b == 2) ? 4'b1111 : 4'b1101;
      for (int c = 0; c < NCH; c++) setChData(c, $urandom);
      #1;
      checkCount++;
      if (rrReady !== modelReady()) $display("[TB] FAIL lock_ready[%0d]: got %b expected %b", b, rrReady, modelReady());
      else passCount++;
      tick();
      checkCount++;
      if (rrSel !== 2'(mSel) || rrData !== mData)
        $display("[TB] FAIL lock_beat[%0d]: got sel=%0d data=%h expected %0d/%h", b, rrSel, rrData, mSel, mData);
      else passCount++;
`ifdef STREAM_MUX_PKT_LOCK_EN
      checkCount++;
      if (rrSel !== 2'(expSel[b])) $display("[TB] FAIL lock_seq[%0d]: got %0d expected %0d", b, rrSel, expSel[b]);
      else passCount++;
      if (b == 1) begin
        valid = 4'b0001;
        #1;
        checkCount++;
        if (rrReady !== 4'b0000) $display("[TB] FAIL lock_hold_gap: got %b expected 0000", rrReady);
        else passCount++;
        tick();
        valid = 4'b0011;
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    valid = 4'b0011; last = 4'b1101; ready = 1;
    tick();
    ready = 0;
    tick();
    checkCount++;
    if (rrValid !== 1'b1) $display("[TB] FAIL midrst_setup: got valid=%b expected 1", rrValid);
    else passCount++;
    rst = 1;
    #1;
    checkCount++;
    if (rrReady !== 4'b0000) $display("[TB] FAIL midrst_ready: got %b expected 0000", rrReady);
    else passCount++;
    tick();
    checkCount++;
    if (rrValid !== 1'b0 || rrSel !== 2'd0)
      $display("[TB] FAIL midrst_regs: got valid=%b sel=%0d expected 0/0", rrValid, rrSel);
    else passCount++;
    rst = 0; ready = 1; valid = 4'b0011;
    #1;
    checkCount++;
    if (rrReady !== 4'b0001) $display("[TB] FAIL midrst_first: got %b expected 0001", rrReady);
    else passCount++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      valid = NCH'($urandom);
      last = NCH'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < NCH; c++) setChData(c, $urandom);
      #1;
      checkCount++;
      if (rrReady !== modelReady()) $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", i, rrReady, modelReady());
      else passCount++;
      tick();
      checkCount++;
      if (rrValid !== mValid || rrData !== mData || rrLast !== mLast || rrSel !== 2'(mSel))
        $display("[TB] FAIL rand_out[%0d]: got v=%b d=%h l=%b s=%0d expected v=%b d=%h l=%b s=%0d",
                 i, rrValid, rrData, rrLast, rrSel, mValid, mData, mLast, mSel);
      else passCount++;
    end
    rst = 0;
  endtask

  // Run every scenario in order, then report
  initial begin
    mValid = 0; mData = '0; mLast = 0; mSel = 0; mLastGrant = NCH - 1; mLocked = 0;
    rst = 1; valid = '0; data = '0; last = '0; ready = 0;
    @(posedge clk); #1;
    test_reset();
    test_rr_sweep();
    test_backpressure();
    test_idle();
    test_fixed_priority();
    test_lock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
- REQ-001 SHALL have parameter NUM_CH, default 16: number of input channels, 2..32.
- REQ-002 SHALL have parameter WIDTH, default 32: data width per channel, 1..64.
- REQ-003 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
- REQ-004 SHALL have port i_clk  input  1: single clock; all state updates on rising edge.
- REQ-005 SHALL have port i_rst  input  1: reset, synchronous, active-high.
- REQ-006 SHALL have port i_valid  input  NUM_CH: per-channel request.
- REQ-007 SHALL have port i_data  input  NUM_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- REQ-008 SHALL have port i_last  input  NUM_CH: per-channel end-of-packet flag.
- REQ-009 SHALL have port o_ready  output  NUM_CH: per-channel accept, one-hot or zero.
- REQ-010 SHALL have port o_valid  output  1: output register holds a beat.
- REQ-011 SHALL have port o_data  output  WIDTH: registered selected data.
- REQ-012 SHALL have port o_last  output  1: registered i_last of the selected channel.
- REQ-013 SHALL have port o_sel  output  $clog2(NUM_CH): registered index of the source channel.
- REQ-014 SHALL have port i_ready  input  1: downstream accept.

Function
- REQ-015 SHALL define load = ~o_valid | i_ready; a beat transfers on channel k when i_valid[k] & o_ready[k].
- REQ-016 SHALL assert o_ready[k] only when load = 1 and channel k is granted; o_ready SHALL be zero when no i_valid is set.
- REQ-017 SHALL capture granted data/last/index into the output register on a transfer, giving 1-cycle latency input to o_valid.
- REQ-018 SHALL clear o_valid when o_valid & i_ready and no transfer occurs in that cycle; SHALL hold o_data/o_last/o_sel stable while o_valid & ~i_ready.
- REQ-019 SHALL sustain one beat per cycle when i_ready stays high (simultaneous drain and load).
- REQ-020 ARB_MODE=0: grant SHALL go to the lowest-index valid channel.
- REQ-021 ARB_MODE=1: grant SHALL go to the first valid channel searching from (last_granted+1) mod NUM_CH upward with wrap-around; last_granted SHALL update only on a transfer.
- REQ-022 Grant SHALL be purely combinational from i_valid and arbiter state; i_valid may drop without a transfer, with no state change.

Reset
- REQ-023 On i_rst high at a clock edge: o_valid = 0, o_data = 0, o_last = 0, o_sel = 0, last_granted = NUM_CH-1 (so channel 0 wins first), lock state cleared.
- REQ-024 o_ready SHALL be all-zero during any cycle with i_rst high; reset mid-packet SHALL discard the held beat and the lock.

Configuration
- REQ-025 Macro STREAM_MUX_PKT_LOCK_EN defined: after a transfer from channel k with i_last[k] = 0, grant SHALL remain locked to k until a transfer with i_last[k] = 1, ignoring other requests even if k deasserts i_valid.
- REQ-026 Macro undefined: arbitration SHALL occur on every beat; i_last is only passed through to o_last.

Structure
- REQ-027 Package stream_mux_pkg SHALL hold ARB_FIXED/ARB_RR mode constants and the default NUM_CH/WIDTH constants.
- REQ-028 Arbitration SHALL live in sub-module rr_arbiter (parameters NUM_CH, ARB_MODE; inputs request, advance, lock; outputs one-hot grant and index); datapath select and output register stay in stream_mux_rr.

Verification (NUM_CH=4, WIDTH=32, ARB_MODE=1)
- REQ-029 Reset then i_valid=4'b1111, i_ready=1 constant: o_sel sequence 0,1,2,3,0 on consecutive cycles, o_valid=1 from cycle 2 on.
- REQ-030 Only ch2 valid with i_data ch2=32'hDEAD_BEEF, i_ready=0 for 3 cycles: o_data=32'hDEAD_BEEF held, o_ready=0 until i_ready=1, then next beat accepted same cycle.
- REQ-031 ARB_MODE=0, i_valid=4'b1010 sustained: o_sel always 1, channel 3 never granted.
- REQ-032 Lock macro defined: ch1 sends 3 beats (i_last on 3rd) while ch0 valid throughout: o_sel = 1,1,1 then 0.
- REQ-033 Assert i_rst while o_valid=1 and ch1 locked mid-packet: next cycle o_valid=0, o_ready=0; after release ch0 granted first.
- REQ-034 All i_valid=0 for 5 cycles with i_ready=1: o_valid drops after 1 cycle, o_ready=0, last_granted unchanged.
